// File: rtl/apb_multi_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_multi_slave_mem                                          |
// | Description : APB4 completer modelling up to 16 one-hot-selected memories  |
// |               with per-access wait states, byte strobes and error replies. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module apb_multi_slave_mem #(
    parameter int          ADDRESS_WIDTH     = 32,
    parameter int          DATA_WIDTH        = 32,
    parameter int          NO_OF_SLAVES      = 4,
    parameter int          SLAVE_MEM_WORDS   = 256,
    parameter logic [15:0] SECURE_SLAVE_MASK = 16'h0000
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NO_OF_SLAVES-1:0]   psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                wait_cycles,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr
);

    localparam int c_BYTES   = DATA_WIDTH / 8;
    localparam int c_BYTE_SH = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;
    localparam int c_MEM_AW  = (SLAVE_MEM_WORDS > 1) ? $clog2(SLAVE_MEM_WORDS) : 1;
    localparam int c_SLV_AW  = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam logic [ADDRESS_WIDTH:0] c_WORD_LIMIT = (ADDRESS_WIDTH+1)'(SLAVE_MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        ACCESS     = 3'd2,
        WAIT_STATE = 3'd3,
        NO_STATE   = 3'd7
    } state_t;

    state_t                   r_state;
    state_t                   w_state;
    state_t                   w_next_state;
    logic [3:0]               r_cnt;
    logic [c_SLV_AW-1:0]      r_slv;
    logic [c_MEM_AW-1:0]      r_word;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_BYTES-1:0]       r_strb;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [DATA_WIDTH-1:0]    r_mem [NO_OF_SLAVES][SLAVE_MEM_WORDS];

    logic                     w_sel_any;
    logic                     w_onehot;
    logic [c_SLV_AW-1:0]      w_slv;
    logic [ADDRESS_WIDTH-1:0] w_word;
    logic                     w_err;
    logic                     w_setup;
    logic                     w_complete;
    logic                     w_violation;
    logic                     w_unused;

    assign w_sel_any = |psel;
    assign w_onehot  = $onehot(psel);
    assign w_word    = paddr >> c_BYTE_SH;
    assign w_unused  = ^{pprot[2], pprot[0]};

    always_comb begin
        w_slv = '0;
        for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
            if (psel[i]) begin
                w_slv = c_SLV_AW'(i);
            end
        end
    end

    assign w_err = !w_onehot
                 || ({1'b0, w_word} >= c_WORD_LIMIT)
                 || (SECURE_SLAVE_MASK[w_slv] && pprot[1]);

    // A setup phase may directly follow an access cycle that the requester ended early.
    assign w_setup     = ((r_state == IDLE) || (r_state == ACCESS)) && w_sel_any && !penable;
    assign w_complete  = (r_state == ACCESS) && w_sel_any && penable;
    assign w_violation = (r_state == IDLE) && w_sel_any && penable;

    always_comb begin
        w_state      = r_state;
        w_next_state = r_state;
        if (w_setup) begin
            w_state = SETUP;
        end
        case (w_state)
            IDLE:       w_next_state = IDLE;
            SETUP:      w_next_state = (wait_cycles == 4'd0) ? ACCESS : WAIT_STATE;
            WAIT_STATE: begin
                if (!w_sel_any) begin
                    w_next_state = IDLE;
                end else if (penable && (r_cnt == 4'd1)) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS:     w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_cnt   <= '0;
            r_slv   <= '0;
            r_word  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            for (int s = 0; s < NO_OF_SLAVES; s++) begin
                for (int w = 0; w < SLAVE_MEM_WORDS; w++) begin
                    r_mem[s][w] <= '0;
                end
            end
        end else begin
            if (w_setup) begin
                r_cnt   <= wait_cycles;
                r_slv   <= w_slv;
                r_word  <= w_word[c_MEM_AW-1:0];
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_err   <= w_err;
                r_rdata <= r_mem[w_slv][w_word[c_MEM_AW-1:0]];
            end else if ((r_state == WAIT_STATE) && w_sel_any && penable) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_complete && r_write && !r_err) begin
                for (int b = 0; b < c_BYTES; b++) begin
                    if (r_strb[b]) begin
                        r_mem[r_slv][r_word][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Outputs are forced quiet while reset is held, even if the bus is active.
    assign pready  = preset_n && (w_complete || w_violation);
    assign pslverr = preset_n && (w_violation || (w_complete && r_err));
    assign prdata  = (preset_n && w_complete && !r_write && !r_err) ? r_rdata : '0;

endmodule
`default_nettype wire
